// File: rtl/forwarding_unit.sv
// EX-stage bypass selector: picks the youngest in-flight result whose destination matches rs/rt.
// Optional FWD_REG0_GUARD_EN: when defined, register index 0 ($zero) never produces a hit.
module forwarding_unit #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data1,
  input  logic [DATA_W-1:0] data2,
  input  logic [REG_W-1:0]  nextRD,
  input  logic [REG_W-1:0]  nextnextRD,
  input  logic [REG_W-1:0]  rs,
  input  logic [REG_W-1:0]  rt,
  output logic [DATA_W-1:0] outData,
  output logic              first,
  output logic              second
);

  logic rd1_valid;
  logic rd2_valid;
  logic hit1;
  logic hit2;

`ifdef FWD_REG0_GUARD_EN
  assign rd1_valid = (nextRD != '0);
  assign rd2_valid = (nextnextRD != '0);
`else
  assign rd1_valid = 1'b1;
  assign rd2_valid = 1'b1;
`endif

  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    hit1 = ((nextRD == rs) || (nextRD == rt)) && rd1_valid;
    hit2 = ((nextnextRD == rs) || (nextnextRD == rt)) && rd2_valid;
  end

  // hit1 has priority: the EX/MEM producer is younger than MEM/WB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outData <= '0;
      first   <= 1'b0;
      second  <= 1'b0;
    end else begin
      first  <= hit1;
      second <= hit2 & ~hit1;
      if (hit1)
        outData <= data1;
      else if (hit2)
        outData <= data2;
      else
        outData <= '0;
    end
  end

endmodule

// File: tb/tb_forwarding_unit.sv
// Directed table-driven bench for forwarding_unit, plus reset and latency sequences.
module tb_forwarding_unit;

`ifdef FWD_REG0_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [31:0] data1, data2;
  logic [4:0]  nextRD, nextnextRD, rs, rt;
  logic [31:0] outData;
  logic        first, second;

  int checks = 0;
  int errors = 0;

  forwarding_unit #(.DATA_W(32), .REG_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .data1(data1), .data2(data2),
    .nextRD(nextRD), .nextnextRD(nextnextRD),
    .rs(rs), .rt(rt),
    .outData(outData), .first(first), .second(second)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d1, d2;
    logic [4:0]  nrd, nnrd, rs, rt;
    logic [31:0] eout;
    logic        ef, es;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [31:0] d1, input logic [31:0] d2,
                     input logic [4:0] nrd, input logic [4:0] nnrd,
                     input logic [4:0] s, input logic [4:0] t,
                     input logic [31:0] eout, input logic ef, input logic es);
    vec_t v;
    v.d1 = d1; v.d2 = d2; v.nrd = nrd; v.nnrd = nnrd; v.rs = s; v.rt = t;
    v.eout = eout; v.ef = ef; v.es = es;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    data1 = v.d1; data2 = v.d2; nextRD = v.nrd; nextnextRD = v.nnrd; rs = v.rs; rt = v.rt;
  endtask

  task automatic check_outs(input string tag, input logic [31:0] eout, input logic ef, input logic es);
    chk({tag, ".outData"}, outData, eout);
    chk({tag, ".first"},   {31'b0, first},  {31'b0, ef});
    chk({tag, ".second"},  {31'b0, second}, {31'b0, es});
  endtask

  initial begin
    vec_t a, b;

    // Rows from the block description
    add(3, 4, 7, 1, 1, 4,                 4, 1'b0, 1'b1);
    add(56, 76, 8, 1, 6, 1,               76, 1'b0, 1'b1);
    add(234, 324, 23, 1, 0, 23,           234, 1'b1, 1'b0);
    add(43214, 213443, 23, 11, 23, 12,    43214, 1'b1, 1'b0);
    // All zero: guarded -> no hit; unguarded -> first hit forwarding data1 (=0)
    add(0, 0, 0, 0, 0, 0,                 0, !GUARD, 1'b0);
    add(9, 7, 5, 5, 5, 0,                 9, 1'b1, 1'b0);
    // No match anywhere
    add(32'h1234_5678, 32'h9abc_def0, 3, 4, 5, 6, 0, 1'b0, 1'b0);
    // rs and rt both equal nextRD: single hit, all bits forwarded
    add(32'hffff_ffff, 32'h0000_0001, 31, 2, 31, 31, 32'hffff_ffff, 1'b1, 1'b0);
    // rt matches nextRD, rs matches nextnextRD: nextRD wins
    add(32'haaaa_5555, 32'h5555_aaaa, 10, 20, 20, 10, 32'haaaa_5555, 1'b1, 1'b0);
    // nextnextRD via rs only, MSB data
    add(32'h0000_0011, 32'h8000_0001, 12, 30, 30, 1, 32'h8000_0001, 1'b0, 1'b1);
    // Index 0 on both producers
    add(32'h11, 32'h22, 0, 0, 0, 9,       GUARD ? 32'h0 : 32'h11, !GUARD, 1'b0);
    // Index 0 on nextRD with real hit on nextnextRD
    add(32'h33, 32'h44, 0, 3, 0, 3,       GUARD ? 32'h44 : 32'h33, !GUARD, GUARD);

    // Async reset: capture a hit, then drop rst_n between edges
    rst_n = 1'b1;
    data1 = 32'h0000_00aa; data2 = 32'h0000_00bb;
    nextRD = 3; nextnextRD = 4; rs = 3; rt = 8;
    #6;  // just after the first rising edge at t=5
    check_outs("pre_reset", 32'haa, 1'b1, 1'b0);
    #1 rst_n = 1'b0;
    #1 check_outs("async_reset", 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_outs("reset_held", 32'h0, 1'b0, 1'b0);
    @(negedge clk) rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      @(posedge clk); #1;
      check_outs($sformatf("vec%0d", i), vecs[i].eout, vecs[i].ef, vecs[i].es);
    end

    // One-cycle latency: new inputs are invisible until the next rising edge
    a = vecs[0];
    b = vecs[3];
    @(negedge clk); drive(a);
    @(posedge clk); #1;
    check_outs("lat_a", a.eout, a.ef, a.es);
    @(negedge clk); drive(b);
    #1 check_outs("lat_hold", a.eout, a.ef, a.es);
    @(posedge clk); #1;
    check_outs("lat_b", b.eout, b.ef, b.es);

    // Reset mid-stream discards the pending result; recovery on next edge
    @(negedge clk); rst_n = 1'b0;
    #1 check_outs("mid_reset", 32'h0, 1'b0, 1'b0);
    @(negedge clk); rst_n = 1'b1; drive(a);
    #1 check_outs("post_release", 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_outs("recover", a.eout, a.ef, a.es);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
